pb_debounce_sel: RTL

//  Upstream conditioning stage for the 4-bit 2:1 LED mux lab: turns the raw,

---
 rtl/pb_debounce_sel.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pb_debounce_sel.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM, press/release strobes,
// toggling mux select and a wrapping press counter.
module pb_debounce_sel #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter logic        SEL_INIT        = 1'b0,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pb_raw,
    output logic             pb_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             sel,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned     DB_W         = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic            RAW_RELEASED = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_e;

    logic             sync1_q, sync2_q;
    logic             pressed_c;
    state_e           state_q, state_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Polarity-normalised synchronized button: 1 = pressed
    assign pressed_c = sync2_q ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= RAW_RELEASED;
            sync2_q   <= RAW_RELEASED;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            sel_q     <= SEL_INIT;
            count_q   <= '0;
        end else begin
            sync1_q   <= pb_raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            sel_q     <= sel_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        sel_d     = sel_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (pressed_c) begin
                    state_d = DB_PRESS;
                    cnt_d   = '0;
                end
            end
            DB_PRESS: begin
                if (!pressed_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    sel_d   = ~sel_q;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (!pressed_c) begin
                    state_d = DB_REL;
                    cnt_d   = '0;
                end
            end
            DB_REL: begin
                if (pressed_c) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pb_level      = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign sel           = sel_q;
    assign press_count   = count_q;

endmodule
